riscv_mtimer: RTL and testbench
===============================

// Module: riscv_mtimer
// PURPOSE
//  Machine timer peripheral: 64-bit mtime counter, mtimecmp compare and optional auto-reload.
//  Sits on the data-memory bus beside the core and drives timer_irq into riscv_control,
//  which latches it into mip[7] (MTIP). One instance per core.
// PARAMETERS
//  PRESCALE_W   8        width of prescaler divisor field; mtime ticks every (DIV+1) clk
//  RESET_EN     0        value of CTRL.EN after reset
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, asynchronous, active-high
//  sel          in   1   bus select, timer address window decoded upstream
//  we           in   1   write strobe (valid with sel)
//  addr         in   3   word offset: 0 MTIME_LO,1 MTIME_HI,2 CMP_LO,3 CMP_HI,4 PERIOD,5 CTRL
//  wdata        in   32  write data, full-word writes only
//  rdata        out  32  read data, combinational from sel/addr; 0 when ~sel or offset 6..7
//  timer_irq    out  1   registered interrupt request to riscv_control
// BEHAVIOUR
//  Reset (async): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, period=0, prescaler=0, match_q=0,
//   CTRL={DIV=0, RELOAD=0, PULSE=0, EN=RESET_EN}, timer_irq=0. Reset mid-count discards all state.
//  CTRL layout: [0] EN, [1] PULSE, [2] RELOAD, [8 +: PRESCALE_W] DIV; other bits read 0.
//  Prescaler: counts 0..DIV while EN; tick=1 on the cycle it equals DIV, then returns to 0.
//   EN=0 holds prescaler and mtime. DIV write resets prescaler to 0 same edge.
//  mtime: +1 on tick, unsigned mod 2^64 (FFFF..FF -> 0 wraps, no flag).
//  match = (mtime >= mtimecmp), unsigned 64-bit, combinational on current register values.
//  timer_irq (registered, 1-cycle latency after match becomes true):
//   PULSE=0: timer_irq <= EN & match (level; cleared by raising mtimecmp or EN=0).
//   PULSE=1: timer_irq <= EN & match & ~match_q (one-cycle pulse per rising edge of match).
//   match_q <= match every cycle regardless of EN.
//  RELOAD=1: on a tick cycle where match is true, mtimecmp <= mtimecmp + {32'b0, period}
//   (mod 2^64). period=0 with RELOAD=1 leaves mtimecmp unchanged (match stays true).
//  Bus write priority: a bus write to a register wins over tick increment/reload that cycle;
//   the other half of a 64-bit register is untouched (increment is lost for that cycle).
//  MTIME_LO write does not carry into MTIME_HI. Software writes CMP_HI=FFFF_FFFF first to
//   avoid spurious match; hardware performs no atomicity.
//  Reads return current register value (pre-edge); read of CTRL returns reserved bits as 0.
//  Simultaneous tick + match + CTRL write clearing EN: write wins, no reload, irq drops next cycle.
// STRUCTURE
//  riscv_mtimer_pkg: register offsets (MTIMER_MTIME_LO..MTIMER_CTRL), CTRL bit indices,
//   MTIMECMP reset constant.
//  Sub-module riscv_mtimer_prescaler: DIV compare counter, inputs en/div/clr, output tick.
//  Top: register file, bus decode/read mux, compare, reload adder, irq register.
// TESTING
//  1 Reset: assert rst mid-count -> rdata all regs as reset values, timer_irq=0 immediately.
//  2 Level: EN=1,DIV=0,CMP=10 -> mtime=10 at cycle 10, timer_irq=1 at cycle 11, stays 1;
//    write CMP_LO=100 -> timer_irq=0 next cycle.
//  3 Prescale: DIV=3,EN=1 -> mtime increments every 4th clk; after 40 clk MTIME_LO=10.
//  4 Wrap: MTIME_LO/HI=FFFF_FFFF, tick -> mtime=0; CMP=FFFF_FFFF_FFFF_FFFF, match true before wrap only.
//  5 Periodic pulse: PULSE=1,RELOAD=1,PERIOD=5,CMP=5,DIV=0 -> single-cycle pulses at mtime 5,10,15
//    (irq one cycle later), CMP reads 10,15,20 after each.
//  6 Collision: bus write MTIME_LO=50 on a tick cycle -> reads 50, not 51; EN=0 write on
//    matching tick -> no reload, timer_irq=0 following cycle.

Source files
------------

// File: rtl/riscv_mtimer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mtimer_pkg
// Description : Register offsets, CTRL bit positions and reset constants
//               shared by the machine timer peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mtimer_pkg;

    localparam logic [2:0] MTIMER_MTIME_LO = 3'd0;
    localparam logic [2:0] MTIMER_MTIME_HI = 3'd1;
    localparam logic [2:0] MTIMER_CMP_LO   = 3'd2;
    localparam logic [2:0] MTIMER_CMP_HI   = 3'd3;
    localparam logic [2:0] MTIMER_PERIOD   = 3'd4;
    localparam logic [2:0] MTIMER_CTRL     = 3'd5;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_PULSE_BIT  = 1;
    localparam int CTRL_RELOAD_BIT = 2;
    localparam int CTRL_DIV_LSB    = 8;

    localparam logic [63:0] MTIMER_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/riscv_mtimer_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mtimer_if
// Description : Data-memory bus slice seen by the machine timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_mtimer_if;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/riscv_mtimer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mtimer_prescaler
// Description : Divide-by-(DIV+1) tick generator for the mtime counter.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mtimer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  en,
    input  wire logic [PRESCALE_W-1:0] div,
    input  wire logic                  clr,
    output logic                       tick
);

    logic [PRESCALE_W-1:0] r_count;

    assign tick = en & (r_count == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= tick ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_mtimer.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mtimer
// Description : 64-bit machine timer with compare, auto-reload and
//               level/pulse interrupt generation.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mtimer
    import riscv_mtimer_pkg::*;
#(
    parameter int PRESCALE_W = 8,
    parameter bit RESET_EN   = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    riscv_mtimer_if.slave   bus,
    output logic            timer_irq
);

    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic [31:0]           r_period;
    logic                  r_en;
    logic                  r_pulse;
    logic                  r_reload;
    logic [PRESCALE_W-1:0] r_div;
    logic                  r_match_q;
    logic                  r_irq;

    logic w_wr;
    logic w_wr_mlo, w_wr_mhi, w_wr_clo, w_wr_chi, w_wr_per, w_wr_ctrl;
    logic w_tick, w_tick_eff, w_en_clear, w_match;
    logic [31:0] w_ctrl_rd;

    assign w_wr      = bus.sel & bus.we;
    assign w_wr_mlo  = w_wr & (bus.addr == MTIMER_MTIME_LO);
    assign w_wr_mhi  = w_wr & (bus.addr == MTIMER_MTIME_HI);
    assign w_wr_clo  = w_wr & (bus.addr == MTIMER_CMP_LO);
    assign w_wr_chi  = w_wr & (bus.addr == MTIMER_CMP_HI);
    assign w_wr_per  = w_wr & (bus.addr == MTIMER_PERIOD);
    assign w_wr_ctrl = w_wr & (bus.addr == MTIMER_CTRL);

    // A CTRL write that disables the timer overrides any tick in the same cycle.
    assign w_en_clear = w_wr_ctrl & ~bus.wdata[CTRL_EN_BIT];
    assign w_tick_eff = w_tick & ~w_en_clear;
    assign w_match    = (r_mtime >= r_mtimecmp);

    riscv_mtimer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (r_en),
        .div  (r_div),
        .clr  (w_wr_ctrl),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime <= '0;
        end else if (w_wr_mlo) begin
            r_mtime[31:0] <= bus.wdata;
        end else if (w_wr_mhi) begin
            r_mtime[63:32] <= bus.wdata;
        end else if (w_tick_eff) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtimecmp <= MTIMER_CMP_RESET;
        end else if (w_wr_clo) begin
            r_mtimecmp[31:0] <= bus.wdata;
        end else if (w_wr_chi) begin
            r_mtimecmp[63:32] <= bus.wdata;
        end else if (w_tick_eff & r_reload & w_match) begin
            r_mtimecmp <= r_mtimecmp + {32'b0, r_period};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= '0;
            r_en     <= RESET_EN;
            r_pulse  <= 1'b0;
            r_reload <= 1'b0;
            r_div    <= '0;
        end else begin
            if (w_wr_per) begin
                r_period <= bus.wdata;
            end
            if (w_wr_ctrl) begin
                r_en     <= bus.wdata[CTRL_EN_BIT];
                r_pulse  <= bus.wdata[CTRL_PULSE_BIT];
                r_reload <= bus.wdata[CTRL_RELOAD_BIT];
                r_div    <= bus.wdata[CTRL_DIV_LSB +: PRESCALE_W];
            end
        end
    end

    // Pulse mode only fires on the rising edge of the compare result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_q <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_match_q <= w_match;
            r_irq     <= r_en & w_match & (~r_pulse | ~r_match_q);
        end
    end

    assign timer_irq = r_irq;

    always_comb begin
        w_ctrl_rd                                 = '0;
        w_ctrl_rd[CTRL_EN_BIT]                    = r_en;
        w_ctrl_rd[CTRL_PULSE_BIT]                 = r_pulse;
        w_ctrl_rd[CTRL_RELOAD_BIT]                = r_reload;
        w_ctrl_rd[CTRL_DIV_LSB +: PRESCALE_W]     = r_div;
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (bus.addr)
                MTIMER_MTIME_LO: bus.rdata = r_mtime[31:0];
                MTIMER_MTIME_HI: bus.rdata = r_mtime[63:32];
                MTIMER_CMP_LO:   bus.rdata = r_mtimecmp[31:0];
                MTIMER_CMP_HI:   bus.rdata = r_mtimecmp[63:32];
                MTIMER_PERIOD:   bus.rdata = r_period;
                MTIMER_CTRL:     bus.rdata = w_ctrl_rd;
                default:         bus.rdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mtimer.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_mtimer
// Description : Directed self-checking bench for the machine timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mtimer;
    import riscv_mtimer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timer_irq;
    int   n_tests = 0;
    int   n_fail  = 0;

    riscv_mtimer_if bus();

    riscv_mtimer #(.PRESCALE_W(8), .RESET_EN(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        #1;
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1;
        d = bus.rdata;
        bus.sel = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_v [0:6];
        exp_v = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        do_reset();
        bus_write(MTIMER_CMP_HI, 32'h0);
        bus_write(MTIMER_CMP_LO, 32'd2);
        bus_write(MTIMER_PERIOD, 32'd7);
        bus_write(MTIMER_CTRL, 32'h0000_0201);
        repeat (8) @(posedge clk);
        #1;
        n_tests++;
        if (timer_irq !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_irq: got %b want 1", timer_irq);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq_async: got %b want 0", timer_irq);
        end
        for (int i = 0; i < 7; i++) begin
            bus_read(3'(i), d);
            n_tests++;
            if (d !== exp_v[i]) begin
                n_fail++; $display("FAIL reset_reg%0d: got %h want %h", i, d, exp_v[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_level();
        logic [31:0] d;
        do_reset();
        bus_write(MTIMER_CMP_HI, 32'h0);
        bus_write(MTIMER_CMP_LO, 32'd10);
        bus_write(MTIMER_CTRL, 32'h1);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) begin
                bus_read(MTIMER_MTIME_LO, d);
                n_tests++;
                if (d !== 32'd10) begin
                    n_fail++; $display("FAIL level_mtime10: got %0d want 10", d);
                end
                n_tests++;
                if (timer_irq !== 1'b0) begin
                    n_fail++; $display("FAIL level_irq_c10: got %b want 0", timer_irq);
                end
            end
            if (k == 11) begin
                n_tests++;
                if (timer_irq !== 1'b1) begin
                    n_fail++; $display("FAIL level_irq_c11: got %b want 1", timer_irq);
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (timer_irq !== 1'b1) begin
            n_fail++; $display("FAIL level_irq_hold: got %b want 1", timer_irq);
        end
        bus.addr = MTIMER_MTIME_LO; bus.sel = 1'b0;
        #1;
        n_tests++;
        if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL rdata_nosel: got %h want 0", bus.rdata);
        end
        bus_write(MTIMER_CMP_LO, 32'd100);
        @(posedge clk);
        #1;
        n_tests++;
        if (timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL level_irq_clear: got %b want 0", timer_irq);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        do_reset();
        bus_write(MTIMER_CTRL, 32'h0000_0301);
        bus_read(MTIMER_CTRL, d);
        n_tests++;
        if (d !== 32'h0000_0301) begin
            n_fail++; $display("FAIL prescale_ctrl: got %h want 00000301", d);
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 39 || k == 40) begin
                bus_read(MTIMER_MTIME_LO, d);
                n_tests++;
                if (d !== ((k == 40) ? 32'd10 : 32'd9)) begin
                    n_fail++; $display("FAIL prescale_k%0d: got %0d want %0d", k, d, (k == 40) ? 10 : 9);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [31:0] h;
        do_reset();
        bus_write(MTIMER_MTIME_LO, 32'hFFFF_FFFF);
        bus_write(MTIMER_MTIME_HI, 32'hFFFF_FFFF);
        bus_read(MTIMER_CMP_LO, d);
        n_tests++;
        if (d !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_cmp_reset: got %h want ffffffff", d);
        end
        bus_write(MTIMER_CTRL, 32'h1);
        n_tests++;
        if (timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL wrap_irq_pre: got %b want 0", timer_irq);
        end
        @(posedge clk);
        #1;
        bus_read(MTIMER_MTIME_LO, d);
        bus_read(MTIMER_MTIME_HI, h);
        n_tests++;
        if ({h, d} !== 64'h0) begin
            n_fail++; $display("FAIL wrap_mtime: got %h want 0", {h, d});
        end
        n_tests++;
        if (timer_irq !== 1'b1) begin
            n_fail++; $display("FAIL wrap_irq_before: got %b want 1", timer_irq);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL wrap_irq_after: got %b want 0", timer_irq);
        end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        logic        irq_exp;
        logic [31:0] cmp_exp;
        do_reset();
        bus_write(MTIMER_PERIOD, 32'd5);
        bus_write(MTIMER_CMP_HI, 32'h0);
        bus_write(MTIMER_CMP_LO, 32'd5);
        bus_write(MTIMER_CTRL, 32'h7);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            irq_exp = (k == 6) || (k == 11) || (k == 16);
            cmp_exp = (k < 6) ? 32'd5 : (k < 11) ? 32'd10 : (k < 16) ? 32'd15 : 32'd20;
            n_tests++;
            if (timer_irq !== irq_exp) begin
                n_fail++; $display("FAIL periodic_irq_k%0d: got %b want %b", k, timer_irq, irq_exp);
            end
            if (k == 5 || k == 6 || k == 11 || k == 16) begin
                bus_read(MTIMER_CMP_LO, d);
                n_tests++;
                if (d !== cmp_exp) begin
                    n_fail++; $display("FAIL periodic_cmp_k%0d: got %0d want %0d", k, d, cmp_exp);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        do_reset();
        bus_write(MTIMER_CTRL, 32'h1);
        repeat (3) @(posedge clk);
        bus_write(MTIMER_MTIME_LO, 32'd50);
        bus_read(MTIMER_MTIME_LO, d);
        n_tests++;
        if (d !== 32'd50) begin
            n_fail++; $display("FAIL collide_mtime: got %0d want 50", d);
        end
        do_reset();
        bus_write(MTIMER_PERIOD, 32'd5);
        bus_write(MTIMER_CMP_HI, 32'h0);
        bus_write(MTIMER_CMP_LO, 32'd3);
        bus_write(MTIMER_CTRL, 32'h5);
        repeat (3) @(posedge clk);
        #1;
        bus_write(MTIMER_CTRL, 32'h0);
        bus_read(MTIMER_CMP_LO, d);
        n_tests++;
        if (d !== 32'd3) begin
            n_fail++; $display("FAIL collide_noreload: got %0d want 3", d);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL collide_irq: got %b want 0", timer_irq);
        end
    endtask

    initial begin
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_level();
        test_prescale();
        test_wrap();
        test_periodic();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
